// File: rtl/led_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_driver_pkg
// Description : Shared types, constants and register-map helpers for the
//               LED driver register bank and its auto-increment pointer.
// Revision    : 1.0 - parametrised register bank with auto-increment
// ============================================================================
package led_driver_pkg;

    // MODE register layout: auto-increment field, sleep flag, sub-address bits
    typedef struct packed {
        logic [2:0] ai;
        logic       sleep;
        logic [3:0] sub;
    } reg_mode_t;

    // Per-channel output selection held in the LEDOUT bytes
    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_ON      = 2'b01,
        LED_PWM     = 2'b10,
        LED_PWM_GRP = 2'b11
    } led_out_enum_t;

    // Auto-increment modes; any value with bit 2 clear disables increment
    typedef enum logic [2:0] {
        AI_OFF     = 3'b000,
        AI_ALL     = 3'b100,
        AI_PWM     = 3'b101,
        AI_GRP     = 3'b110,
        AI_PWM_GRP = 3'b111
    } ai_mode_enum_t;

    // Sleep set, auto-increment off
    localparam logic [7:0] MODE_RESET = 8'h10;

    // Four LEDs share one LEDOUT byte
    function automatic int ledout_regs(input int n);
        return (n + 3) / 4;
    endfunction

    function automatic int reg_count(input int n);
        return n + 3 + ledout_regs(n);
    endfunction

    function automatic int grppwm_addr(input int n);
        return n + 1;
    endfunction

    function automatic int grpfreq_addr(input int n);
        return n + 2;
    endfunction

    function automatic int ledout_base(input int n);
        return n + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_ai_ptr.sv
`default_nettype none
// ============================================================================
// Module      : led_ai_ptr
// Description : Combinational next-address function for the register-bank
//               auto-increment pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module led_ai_ptr
    import led_driver_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int ADDR_BITS = 3
)(
    input  logic [ADDR_BITS-1:0] cur_addr,
    input  logic [2:0]           ai,
    output logic [ADDR_BITS-1:0] next_addr
);

    localparam int NUM_REGS = reg_count(NUM_LEDS);
    localparam int GRP_LO   = grppwm_addr(NUM_LEDS);
    localparam int GRP_HI   = grpfreq_addr(NUM_LEDS);

    int a;

    // Select the successor address for the active auto-increment ring
    always_comb begin
        a         = int'(cur_addr);
        next_addr = cur_addr;
        case (ai)
            AI_ALL:     next_addr = (a >= NUM_REGS - 1) ? '0 : ADDR_BITS'(a + 1);
            AI_PWM:     next_addr = (a >= 1 && a < NUM_LEDS) ? ADDR_BITS'(a + 1)
                                                             : ADDR_BITS'(1);
            AI_GRP:     next_addr = (a == GRP_LO) ? ADDR_BITS'(GRP_HI)
                                                  : ADDR_BITS'(GRP_LO);
            AI_PWM_GRP: next_addr = (a >= 1 && a < GRP_HI) ? ADDR_BITS'(a + 1)
                                                           : ADDR_BITS'(1);
            default:    next_addr = cur_addr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : led_reg_bank
// Description : Parametrised LED driver register bank (MODE, PWM, GRPPWM,
//               GRPFREQ, LEDOUT) with an auto-increment address pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module led_reg_bank
    import led_driver_pkg::*;
#(
    parameter  int NUM_LEDS    = 4,
    parameter  int DATA_BITS   = 8,
    localparam int LEDOUT_REGS = ledout_regs(NUM_LEDS),
    localparam int NUM_REGS    = NUM_LEDS + 3 + LEDOUT_REGS,
    localparam int ADDR_BITS   = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          addr_load,
    input  logic [ADDR_BITS-1:0]          addr,
    input  logic                          w_en,
    input  logic                          r_en,
    input  logic [DATA_BITS-1:0]          wdata,
    output logic [DATA_BITS-1:0]          rdata,
    output logic                          rvalid,
    output logic [ADDR_BITS-1:0]          ptr,
    output logic [DATA_BITS-1:0]          mode_o,
    output logic [NUM_LEDS*DATA_BITS-1:0] pwm_o,
    output logic [DATA_BITS-1:0]          grppwm_o,
    output logic [DATA_BITS-1:0]          grpfreq_o,
    output logic [2*NUM_LEDS-1:0]         ledout_o
);

    localparam int GRPPWM_ADDR  = grppwm_addr(NUM_LEDS);
    localparam int GRPFREQ_ADDR = grpfreq_addr(NUM_LEDS);
    localparam int LEDOUT_BASE  = ledout_base(NUM_LEDS);

    logic [DATA_BITS-1:0] mode_reg;
    logic [DATA_BITS-1:0] grppwm_reg;
    logic [DATA_BITS-1:0] grpfreq_reg;
    logic [DATA_BITS-1:0] pwm_reg    [NUM_LEDS];
    logic [1:0]           ledout_reg [NUM_LEDS];
    logic [ADDR_BITS-1:0] ptr_reg;
    logic [ADDR_BITS-1:0] eff_addr;
    logic [ADDR_BITS-1:0] next_ptr;
    logic [DATA_BITS-1:0] read_val;
    logic                 strobe;
    logic                 do_read;
    int                   ea;

    assign eff_addr = addr_load ? addr : ptr_reg;
    assign strobe   = w_en | r_en;
    assign do_read  = r_en & ~w_en;

    // AI field comes from the stored MODE, so a MODE write takes effect next cycle
    led_ai_ptr #(
        .NUM_LEDS  (NUM_LEDS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ai_ptr (
        .cur_addr  (eff_addr),
        .ai        (mode_reg[7:5]),
        .next_addr (next_ptr)
    );

    // Read decode; unmapped addresses and unused LEDOUT bits read as zero
    always_comb begin
        ea       = int'(eff_addr);
        read_val = '0;
        if (ea == 0)            read_val = mode_reg;
        if (ea == GRPPWM_ADDR)  read_val = grppwm_reg;
        if (ea == GRPFREQ_ADDR) read_val = grpfreq_reg;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (ea == i + 1) read_val = pwm_reg[i];
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (ea == LEDOUT_BASE + i / 4) read_val[2*(i%4) +: 2] = ledout_reg[i];
        end
    end

    // Register storage and write decode; out-of-range writes match nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg    <= DATA_BITS'(MODE_RESET);
            grppwm_reg  <= '0;
            grpfreq_reg <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                pwm_reg[i]    <= '0;
                ledout_reg[i] <= 2'b00;
            end
        end else if (w_en) begin
            if (ea == 0)            mode_reg    <= wdata;
            if (ea == GRPPWM_ADDR)  grppwm_reg  <= wdata;
            if (ea == GRPFREQ_ADDR) grpfreq_reg <= wdata;
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (ea == i + 1) pwm_reg[i] <= wdata;
                if (ea == LEDOUT_BASE + i / 4) ledout_reg[i] <= wdata[2*(i%4) +: 2];
            end
        end
    end

    // Pointer: any strobe advances from the effective address, a bare load just loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (strobe) begin
            ptr_reg <= next_ptr;
        end else if (addr_load) begin
            ptr_reg <= addr;
        end
    end

    // Registered read port; a simultaneous write suppresses the read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= do_read;
            if (do_read) rdata <= read_val;
        end
    end

    assign ptr       = ptr_reg;
    assign mode_o    = mode_reg;
    assign grppwm_o  = grppwm_reg;
    assign grpfreq_o = grpfreq_reg;

    generate
        for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
            assign pwm_o[g*DATA_BITS +: DATA_BITS] = pwm_reg[g];
            assign ledout_o[2*g +: 2]              = ledout_reg[g];
        end
    endgenerate

endmodule
`default_nettype wire
